pulse_stretcher: RTL and testbench

- Inverse of the input button-shaping path: turns single-cycle high request pulses from game logic into long, human-visible active-low pulses.
- Output drives an active-low LED or indicator, or emulates a button press toward a button-shaped input.
- Requests arriving while an output pulse is in progress are queued in a saturating counter and replayed back-to-back, with a guaranteed inactive gap between pulses.

---
 rtl/pulse_stretcher_pkg.sv | 21 ++
 rtl/tick_prescaler.sv | 32 +++
 rtl/pulse_stretcher.sv | 121 ++++++++++++
 tb/tb_pulse_stretcher.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and timing defaults for the pulse stretcher and the
// button input path that uses the same timebase.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } ps_state_e;

  localparam int unsigned DEF_TICK_DIV  = 50000;
  localparam int unsigned DEF_ON_TICKS  = 100;
  localparam int unsigned DEF_GAP_TICKS = 50;
  localparam int unsigned DEF_PEND_W    = 3;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 divider; tick is high on the terminal
// count. restart forces the count back to zero.
module tick_prescaler
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = cnt_w(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle requests into long active-low pulses,
// queueing requests that arrive while a pulse or gap is running.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned ON_TICKS  = DEF_ON_TICKS,
  parameter int unsigned GAP_TICKS = DEF_GAP_TICKS,
  parameter int unsigned PEND_W    = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              p_in,
  output logic              p_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int unsigned TMAX =
    (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int unsigned TW = cnt_w(TMAX);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  ps_state_e         state_q, state_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              p_out_q, p_out_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              tick;
  logic              restart;
  logic              seg_done;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    pend_d   = pend_q;
    ovf_d    = 1'b0;
    seg_done = tick && (tcnt_q ==
      ((state_q == ACTIVE) ? ON_LAST : GAP_LAST));
    if (tick) tcnt_d = tcnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (p_in) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (p_in) begin
          if (pend_q == PEND_MAX) ovf_d = 1'b1;
          else                    pend_d = pend_q + 1'b1;
        end
        if (seg_done) state_d = GAP;
      end
      GAP: begin
        // A request on the dequeue edge replaces the one taken out.
        if (seg_done) begin
          if (pend_q != '0) begin
            state_d = ACTIVE;
            if (!p_in) pend_d = pend_q - 1'b1;
          end else if (p_in) begin
            state_d = ACTIVE;
          end else begin
            state_d = IDLE;
          end
        end else if (p_in) begin
          if (pend_q == PEND_MAX) ovf_d = 1'b1;
          else                    pend_d = pend_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      state_d = IDLE;
      pend_d  = '0;
      ovf_d   = 1'b0;
    end

    if (state_d != state_q || state_d == IDLE) tcnt_d = '0;
    restart = clr || (state_q == IDLE) || (state_d != state_q);
    p_out_d = (state_d != ACTIVE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      pend_q  <= '0;
      p_out_q <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      pend_q  <= pend_d;
      p_out_q <= p_out_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign p_out    = p_out_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: vector table, directed corner sequences
// and random traffic against a cycle-count reference model.
module tb_pulse_stretcher;

  localparam int TICK_DIV  = 4;
  localparam int ON_TICKS  = 3;
  localparam int GAP_TICKS = 2;
  localparam int PEND_W    = 2;
  localparam int ON_CYC    = ON_TICKS * TICK_DIV;
  localparam int GAP_CYC   = GAP_TICKS * TICK_DIV;
  localparam int MAXP      = (1 << PEND_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic p_in = 1'b0;
  logic p_out;
  logic busy;
  logic [PEND_W-1:0] pending;
  logic overflow;

  always #5 clk = ~clk;

  pulse_stretcher #(
    .TICK_DIV  (TICK_DIV),
    .ON_TICKS  (ON_TICKS),
    .GAP_TICKS (GAP_TICKS),
    .PEND_W    (PEND_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .p_in     (p_in),
    .p_out    (p_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: mode 0 idle, 1 low pulse, 2 gap; m_left = cycles remaining.
  int m_mode = 0;
  int m_left = 0;
  int m_pend = 0;
  bit m_ovf  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic enq(input bit p);
    if (p) begin
      if (m_pend < MAXP) m_pend++;
      else               m_ovf = 1'b1;
    end
  endtask

  task automatic mstep(input bit r, input bit c, input bit p);
    int tot;
    m_ovf = 1'b0;
    if (!r || c) begin
      m_mode = 0;
      m_pend = 0;
      m_left = 0;
    end else if (m_mode == 0) begin
      if (p) begin
        m_mode = 1;
        m_left = ON_CYC;
      end
    end else if (m_mode == 1) begin
      m_left--;
      enq(p);
      if (m_left == 0) begin
        m_mode = 2;
        m_left = GAP_CYC;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        tot = m_pend + int'(p);
        if (tot > 0) begin
          m_mode = 1;
          m_left = ON_CYC;
          m_pend = tot - 1;
        end else begin
          m_mode = 0;
        end
      end else begin
        enq(p);
      end
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit p);
    rst  = r;
    clr  = c;
    p_in = p;
    @(posedge clk);
    mstep(r, c, p);
    #1;
    chk("p_out", p_out, m_mode != 1);
    chk("busy", busy, m_mode != 0);
    chk("pending", pending, m_pend);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic t6(input bit use_clr);
    int busy_cnt;
    busy_cnt = 0;
    for (int e = 0; e < 3; e++) cyc(1'b1, 1'b0, 1'b1);
    chk("t6_pend2", pending, 2);
    idle(3);
    if (use_clr) cyc(1'b1, 1'b1, 1'b0);
    else         cyc(1'b0, 1'b0, 1'b0);
    chk("t6_pout", p_out, 1);
    chk("t6_pend", pending, 0);
    chk("t6_busy", busy, 0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (busy || !p_out) busy_cnt++;
    end
    chk("t6_quiet", busy_cnt, 0);
  endtask

  typedef struct {
    logic       rst;
    logic       clr;
    logic       p_in;
    logic       p_out;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int falls;
    bit prev;
    bit r, c, p;

    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].rst, tbl[i].clr, tbl[i].p_in);
      chk($sformatf("tbl%0d_p_out", i), p_out, tbl[i].p_out);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_pend", i), pending, tbl[i].pend);
      chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].ovf);
    end
    idle(3);

    // Single request.
    cyc(1'b1, 1'b0, 1'b1);
    chk("t2_start", p_out, 0);
    for (int e = 1; e <= 25; e++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (e == 11) chk("t2_low11", p_out, 0);
      if (e == 12) chk("t2_rise12", p_out, 1);
      if (e == 19) chk("t2_busy19", busy, 1);
      if (e == 20) chk("t2_idle20", busy, 0);
      chk("t2_pend", pending, 0);
    end

    // Three back-to-back requests.
    for (int e = 0; e <= 2; e++) cyc(1'b1, 1'b0, 1'b1);
    chk("t3_pend2", pending, 2);
    for (int e = 3; e <= 65; e++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (e == 19) chk("t3_gap19", p_out, 1);
      if (e == 20) chk("t3_low20", p_out, 0);
      if (e == 20) chk("t3_pend20", pending, 1);
      if (e == 40) chk("t3_low40", p_out, 0);
      if (e == 40) chk("t3_pend40", pending, 0);
      if (e == 59) chk("t3_busy59", busy, 1);
      if (e == 60) chk("t3_idle60", busy, 0);
    end

    // Saturation and overflow, counting low windows.
    falls = 0;
    prev  = 1'b1;
    for (int e = 0; e < 100; e++) begin
      cyc(1'b1, 1'b0, e <= 4);
      if (e == 3) chk("t4_sat3", pending, 3);
      if (e == 3) chk("t4_novf3", overflow, 0);
      if (e == 4) chk("t4_ovf4", overflow, 1);
      if (e == 5) chk("t4_ovf5", overflow, 0);
      if (prev && !p_out) falls++;
      prev = p_out;
    end
    chk("t4_windows", falls, 4);

    // Request coinciding with dequeue at max depth.
    for (int e = 0; e <= 20; e++) begin
      cyc(1'b1, 1'b0, (e <= 3) || (e == 20));
      if (e == 19) chk("t5_gap19", p_out, 1);
    end
    chk("t5_active", p_out, 0);
    chk("t5_pend", pending, 3);
    chk("t5_novf", overflow, 0);
    idle(90);
    chk("t5_drained", busy, 0);

    // Reset and clear mid-pulse.
    t6(1'b0);
    t6(1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 399) != 0);
      c = ($urandom_range(0, 199) == 0);
      p = ($urandom_range(0, 5) == 0);
      cyc(r, c, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
